morse_codec: RTL and testbench

Parametrised element-level Morse engine that replaces the fixed decoder/keyboard pairing with one block serving both directions under a `mode` select. In decode mode it times a debounced key line into dot/dash patterns and emits one pattern per character, plus a word-gap marker. In encode mode it accepts patterns over a valid/ready handshake and drives a timed key line. Character-to-pattern lookup stays in the existing table logic upstream and downstream of this block.

---
 rtl/morse_codec.sv | 263 ++++++++++++++++++++++++++
 tb/tb_morse_codec.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_codec.sv
`default_nettype none
// ============================================================================
// Module  : morse_codec
// Brief   : Element-level Morse engine: decodes a timed key line into dot/dash
//           patterns (mode=0) or keys out patterns from a handshake (mode=1).
//           Optional word-gap support is enabled by defining MORSE_WORD_GAP_EN.
// Rev     : 1.0  initial release
// ============================================================================
module morse_codec #(
    parameter int UNIT_CYCLES = 5_000_000,
    parameter int MAX_LEN     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               key_in,
    input  logic [MAX_LEN-1:0] in_bits,
    input  logic [2:0]         in_len,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               key_out,
    output logic [MAX_LEN-1:0] out_bits,
    output logic [2:0]         out_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err,
    output logic               busy
);
    localparam int c_cnt_w = $clog2(5 * UNIT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_sat      = c_cnt_w'(5 * UNIT_CYCLES);
    // The entry edge already sampled the first level, so cnt lags the run by one.
    localparam logic [c_cnt_w-1:0] c_dash_min = c_cnt_w'(2 * UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_char_gap = c_cnt_w'(2 * UNIT_CYCLES - 2);
`ifdef MORSE_WORD_GAP_EN
    localparam logic [c_cnt_w-1:0] c_word_gap = c_cnt_w'(5 * UNIT_CYCLES - 2);
`endif
    localparam logic [c_cnt_w-1:0] c_1u_end   = c_cnt_w'(UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_3u_end   = c_cnt_w'(3 * UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_4u_end   = c_cnt_w'(4 * UNIT_CYCLES - 1);
    localparam logic [2:0]         c_max_len  = 3'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_D_MARK  = 3'd1,
        S_D_SPACE = 3'd2,
        S_E_MARK  = 3'd3,
        S_E_SPACE = 3'd4,
        S_E_GAP   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [MAX_LEN-1:0]   bits_q, bits_d;
    logic [2:0]           len_q, len_d;
    logic                 discard_q, discard_d;
    logic                 key_out_q, key_out_d;
    logic [MAX_LEN-1:0]   out_bits_q, out_bits_d;
    logic [2:0]           out_len_q, out_len_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_last;
    logic                 w_cur_dash;
    logic                 w_emit;
    logic [MAX_LEN-1:0]   w_emit_bits;
    logic [2:0]           w_emit_len;

    assign w_cnt_inc = (cnt_q == c_sat) ? cnt_q : cnt_q + c_one;
    assign w_last    = ((idx_q + 3'd1) == len_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        bits_d      = bits_q;
        len_d       = len_q;
        discard_d   = discard_q;
        key_out_d   = key_out_q;
        out_bits_d  = out_bits_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        w_emit      = 1'b0;
        w_emit_bits = '0;
        w_emit_len  = '0;
        w_cur_dash  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 3'(i)) w_cur_dash = bits_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (in_ready_q && in_valid) begin
                    if (in_len > c_max_len) begin
                        err_d = 1'b1;
                    end else if (in_len == 3'd0) begin
`ifdef MORSE_WORD_GAP_EN
                        state_d = S_E_GAP;
                        cnt_d   = '0;
`else
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d   = S_E_MARK;
                        cnt_d     = '0;
                        idx_d     = '0;
                        bits_d    = in_bits;
                        len_d     = in_len;
                        key_out_d = 1'b1;
                    end
                end else if (!mode && key_in) begin
                    state_d   = S_D_MARK;
                    cnt_d     = '0;
                    bits_d    = '0;
                    len_d     = '0;
                    discard_d = 1'b0;
                end
            end
            S_D_MARK: begin
                if (key_in) begin
                    cnt_d = w_cnt_inc;
                end else begin
                    state_d = S_D_SPACE;
                    cnt_d   = '0;
                    if (!discard_q) begin
                        if (len_q == c_max_len) begin
                            err_d     = 1'b1;
                            discard_d = 1'b1;
                        end else begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (len_q == 3'(i)) bits_d[i] = (cnt_q >= c_dash_min);
                            end
                            len_d = len_q + 3'd1;
                        end
                    end
                end
            end
            S_D_SPACE: begin
                if (key_in) begin
                    state_d = S_D_MARK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (cnt_q == c_char_gap) begin
                        w_emit      = !discard_q;
                        w_emit_bits = bits_q;
                        w_emit_len  = len_q;
                        bits_d      = '0;
                        len_d       = '0;
                        discard_d   = 1'b0;
`ifndef MORSE_WORD_GAP_EN
                        state_d     = S_IDLE;
                        cnt_d       = '0;
`endif
                    end
`ifdef MORSE_WORD_GAP_EN
                    if (cnt_q == c_word_gap) begin
                        w_emit  = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            S_E_MARK: begin
                cnt_d = w_cnt_inc;
                if (cnt_q == (w_cur_dash ? c_3u_end : c_1u_end)) begin
                    state_d   = S_E_SPACE;
                    cnt_d     = '0;
                    key_out_d = 1'b0;
                end
            end
            S_E_SPACE: begin
                cnt_d = w_cnt_inc;
                if (cnt_q == (w_last ? c_3u_end : c_1u_end)) begin
                    cnt_d = '0;
                    if (w_last) begin
                        state_d = S_IDLE;
                        bits_d  = '0;
                        len_d   = '0;
                    end else begin
                        state_d   = S_E_MARK;
                        idx_d     = idx_q + 3'd1;
                        key_out_d = 1'b1;
                    end
                end
            end
            S_E_GAP: begin
                cnt_d = w_cnt_inc;
                if (cnt_q == c_4u_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A same-cycle accept frees the slot, so a new item only drops when still blocked.
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (w_emit) begin
            if (out_valid_q && !out_ready) begin
                err_d = 1'b1;
            end else begin
                out_bits_d  = w_emit_bits;
                out_len_d   = w_emit_len;
                out_valid_d = 1'b1;
            end
        end

        in_ready_d = mode && (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            bits_q      <= '0;
            len_q       <= '0;
            discard_q   <= 1'b0;
            key_out_q   <= 1'b0;
            out_bits_q  <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            bits_q      <= bits_d;
            len_q       <= len_d;
            discard_q   <= discard_d;
            key_out_q   <= key_out_d;
            out_bits_q  <= out_bits_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign key_out   = key_out_q;
    assign out_bits  = out_bits_q;
    assign out_len   = out_len_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_codec.sv
`default_nettype none
// ============================================================================
// Module  : tb_morse_codec
// Brief   : Self-checking bench for morse_codec (U=4, MAX_LEN=5), directed
//           scenarios plus randomized decode/encode against a timing model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_morse_codec;
    localparam int U  = 4;
    localparam int ML = 5;
`ifdef MORSE_WORD_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, mode, key_in, in_valid, out_ready;
    logic [ML-1:0] in_bits;
    logic [2:0]    in_len;
    logic          in_ready, key_out, out_valid, err, busy;
    logic [ML-1:0] out_bits;
    logic [2:0]    out_len;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    logic [7:0] got_q[$];

    morse_codec #(.UNIT_CYCLES(U), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .mode(mode), .key_in(key_in),
        .in_bits(in_bits), .in_len(in_len), .in_valid(in_valid), .in_ready(in_ready),
        .key_out(key_out), .out_bits(out_bits), .out_len(out_len),
        .out_valid(out_valid), .out_ready(out_ready), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (out_valid && out_ready) got_q.push_back({out_len, out_bits});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic v, input int n);
        key_in = v;
        tick(n);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; key_in = 1'b0; in_valid = 1'b0;
        in_bits = '0; in_len = '0; out_ready = 1'b1;
        tick(2);
        total++; if (key_out !== 1'b0)   begin bad++; $display("FAIL rst_key_out got=%b exp=0", key_out); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (err !== 1'b0)       begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if ({out_len, out_bits} !== 8'h00) begin bad++; $display("FAIL rst_out got=%h exp=00", {out_len, out_bits}); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_decode_a();
        int e0;
        got_q.delete();
        mode = 1'b0; out_ready = 1'b1; e0 = err_cnt;
        key(1, 4); key(0, 4); key(1, 12); key(0, 7);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL a_early got=%b exp=0", out_valid); end
        key(0, 1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL a_valid got=%b exp=1", out_valid); end
        total++; if (out_len !== 3'd2)   begin bad++; $display("FAIL a_len got=%0d exp=2", out_len); end
        total++; if (out_bits !== 5'b00010) begin bad++; $display("FAIL a_bits got=%b exp=00010", out_bits); end
`ifdef MORSE_WORD_GAP_EN
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL a_busy got=%b exp=1", busy); end
        key(0, 11);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL word_early got=%b exp=0", out_valid); end
        key(0, 1);
        total++; if (out_valid !== 1'b1 || out_len !== 3'd0) begin bad++; $display("FAIL word_marker got=%b/%0d exp=1/0", out_valid, out_len); end
`else
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL a_busy got=%b exp=0", busy); end
        key(0, 12);
`endif
        tick(2);
        total++; if (got_q.size() != 1 + int'(GAP_EN)) begin bad++; $display("FAIL word_items got=%0d exp=%0d", got_q.size(), 1 + int'(GAP_EN)); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL a_err got=%0d exp=%0d", err_cnt, e0); end
    endtask

    task automatic run_encode(input string name, input logic [ML-1:0] b, input int l);
        logic wave[$];
        bit   legal;
        int   wd, e0;
        wave.delete();
        legal = (l >= 1 && l <= ML) || (l == 0 && GAP_EN);
        if (l == 0) begin
            repeat (4 * U) wave.push_back(1'b0);
        end else if (l <= ML) begin
            for (int i = 0; i < l; i++) begin
                repeat (b[i] ? 3 * U : U) wave.push_back(1'b1);
                repeat ((i == l - 1) ? 3 * U : U) wave.push_back(1'b0);
            end
        end
        mode = 1'b1; wd = 0;
        while (in_ready !== 1'b1 && wd < 200) begin tick(1); wd++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_wait got=%b exp=1", name, in_ready); return; end
        e0 = err_cnt;
        in_bits = b; in_len = 3'(l); in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0; in_bits = ML'($urandom); in_len = 3'($urandom);
        if (legal) begin
            for (int j = 0; j < wave.size(); j++) begin
                total++;
                if (key_out !== wave[j] || in_ready !== 1'b0) begin
                    bad++; $display("FAIL %s_wave cyc=%0d got=%b/%b exp=%b/0", name, j + 1, key_out, in_ready, wave[j]);
                end
                if (j < wave.size() - 1) tick(1);
            end
            tick(1);
            total++; if (in_ready !== 1'b1 || key_out !== 1'b0) begin bad++; $display("FAIL %s_end got=%b/%b exp=1/0", name, in_ready, key_out); end
            total++; if (err_cnt != e0) begin bad++; $display("FAIL %s_err got=%0d exp=%0d", name, err_cnt, e0); end
        end else begin
            total++; if (err !== 1'b1 || key_out !== 1'b0) begin bad++; $display("FAIL %s_illegal got=%b/%b exp=1/0", name, err, key_out); end
            tick(4);
            total++; if (err_cnt != e0 + 1 || key_out !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL %s_illegal_after errs=%0d exp=%0d key=%b busy=%b", name, err_cnt - e0, 1, key_out, busy);
            end
        end
    endtask

    task automatic test_encode();
        run_encode("enc_s", 5'b00000, 3);
        run_encode("enc_gap", ML'($urandom), 0);
        run_encode("enc_over", ML'($urandom), 6);
        for (int k = 0; k < 6; k++) run_encode("enc_rand", ML'($urandom), int'($urandom_range(1, ML)));
    endtask

    task automatic test_overlength();
        int e0;
        mode = 1'b0; out_ready = 1'b1; tick(2);
        e0 = err_cnt;
        for (int i = 0; i < 6; i++) begin
            key(1, 4);
            if (i < 5) key(0, 4);
        end
        key(0, 1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL over_err_pulse got=%b exp=1", err); end
        for (int i = 0; i < 7; i++) begin
            key(0, 1);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL over_valid cyc=%0d got=%b exp=0", i, out_valid); end
        end
        key(0, 14);
        total++; if (err_cnt != e0 + 1) begin bad++; $display("FAIL over_err_count got=%0d exp=%0d", err_cnt - e0, 1); end
    endtask

    task automatic test_backpressure();
        int e0;
        got_q.delete();
        mode = 1'b0; out_ready = 1'b0;
        key(1, 4); key(0, 8);
        total++; if (out_valid !== 1'b1 || out_len !== 3'd1) begin bad++; $display("FAIL bp_e got=%b/%0d exp=1/1", out_valid, out_len); end
        key(0, 2); key(1, 12); key(0, 7);
        e0 = err_cnt;
        key(0, 1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL bp_drop_err got=%b exp=1", err); end
        total++; if (out_valid !== 1'b1 || out_len !== 3'd1 || out_bits !== 5'b00000) begin
            bad++; $display("FAIL bp_hold got=%b/%0d/%b exp=1/1/00000", out_valid, out_len, out_bits);
        end
        out_ready = 1'b1;
        key(0, 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", out_valid); end
        total++; if (got_q.size() < 1 || got_q[0] !== {3'd1, 5'b00000}) begin bad++; $display("FAIL bp_consumed got_n=%0d exp first=20", got_q.size()); end
        key(0, 15);
        total++; if (err_cnt != e0 + 1) begin bad++; $display("FAIL bp_err_count got=%0d exp=%0d", err_cnt - e0, 1); end
        total++; if (got_q.size() != 1 + int'(GAP_EN)) begin bad++; $display("FAIL bp_items got=%0d exp=%0d", got_q.size(), 1 + int'(GAP_EN)); end
    endtask

    task automatic test_random_decode();
        logic [7:0] exp_q[$];
        int e0, exp_err;
        mode = 1'b0; out_ready = 1'b1;
        got_q.delete(); e0 = err_cnt; exp_err = 0;
        for (int c = 0; c < 12; c++) begin
            int ne, m, g;
            bit word;
            logic [ML-1:0] pb;
            pb = '0;
            ne = ($urandom_range(0, 7) == 0) ? int'($urandom_range(ML + 1, 7)) : int'($urandom_range(1, ML));
            for (int k = 0; k < ne; k++) begin
                m = int'($urandom_range(1, 3 * U));
                if (k < ML) pb[k] = (m >= 2 * U);
                key(1, m);
                if (k < ne - 1) key(0, int'($urandom_range(1, 2 * U - 1)));
            end
            word = (c == 11) || ($urandom_range(0, 3) == 0);
            g = word ? int'($urandom_range(5 * U, 6 * U)) : int'($urandom_range(2 * U, 5 * U - 1));
            key(0, g);
            if (ne > ML) exp_err++;
            else exp_q.push_back({3'(ne), pb});
            if (word && GAP_EN) exp_q.push_back(8'h00);
        end
        tick(2);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_item idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (err_cnt - e0 != exp_err) begin bad++; $display("FAIL rnd_err got=%0d exp=%0d", err_cnt - e0, exp_err); end
    endtask

    task automatic test_reset_mid_encode();
        int wd;
        mode = 1'b1; wd = 0;
        while (in_ready !== 1'b1 && wd < 200) begin tick(1); wd++; end
        in_bits = 5'b00001; in_len = 3'd1; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(5);
        total++; if (key_out !== 1'b1) begin bad++; $display("FAIL mid_dash got=%b exp=1", key_out); end
        #2 rst = 1'b1;
        #1;
        total++; if (key_out !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL async_rst got=%b/%b exp=0/0", key_out, in_ready); end
        total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b/%b exp=0/0", busy, err); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || key_out !== 1'b0) begin bad++; $display("FAIL post_rst got=%b/%b exp=1/0", in_ready, key_out); end
    endtask

    initial begin
        test_reset();
        test_decode_a();
        test_encode();
        test_overlength();
        test_backpressure();
        test_random_decode();
        test_reset_mid_encode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
